// File: rtl/sigmoid_nn_pkg.sv
// sigmoid_nn_pkg: shared constants, data type and sigmoid table for the fixed-point sigmoid network
package sigmoid_nn_pkg;
  localparam int WIDTH    = 8;
  localparam int FRAC     = 4;
  localparam int N_INPUTS = 2;
  typedef logic signed [WIDTH-1:0] q_t;
  localparam q_t SIG_TH [16] = '{
    -8'sd54, -8'sd36, -8'sd26, -8'sd20, -8'sd15, -8'sd10, -8'sd6, -8'sd2,
     8'sd3,   8'sd7,   8'sd11,  8'sd16,  8'sd21,  8'sd27,  8'sd37, 8'sd55
  };
  function automatic q_t sigmoid_lut(input q_t z);
    q_t a;
    a = '0;
    for (int k = 0; k < 16; k++) if (z >= SIG_TH[k]) a = a + q_t'(1);
    return a;
  endfunction
endpackage

// File: rtl/sigmoid_act.sv
// sigmoid_act: combinational Q3.4 sigmoid, a = round(16/(1+exp(-z/16)))
module sigmoid_act
  import sigmoid_nn_pkg::*;
(
  input  q_t z,
  output q_t a
);
  // each threshold is where the rounded output steps up by one
  always_comb a = sigmoid_lut(z);
endmodule

// File: rtl/sigmoid_nn_layer0_ctrl.sv
// sigmoid_nn_layer0_ctrl: MAC-completion counter and per-neuron sigmoid activation for layer 0
module sigmoid_nn_layer0_ctrl
  import sigmoid_nn_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic ack,
  output logic ack_mac,
  input  q_t   z0_value,
  input  q_t   z1_value,
  output q_t   a0,
  output q_t   a1
);
  localparam int CNT_W = $clog2(N_INPUTS + 1);
  logic [CNT_W-1:0] cnt;
  // count MAC step acks, saturating at N_INPUTS so late acks are ignored
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt <= '0;
    else if (ack && !ack_mac) cnt <= cnt + CNT_W'(1);
  // decoded from the register so the level is glitch-free
  always_comb ack_mac = cnt == CNT_W'(N_INPUTS);
  sigmoid_act u_act0 (.z(z0_value), .a(a0));
  sigmoid_act u_act1 (.z(z1_value), .a(a1));
endmodule

// File: tb/tb_sigmoid_nn_layer0_ctrl.sv
// tb_sigmoid_nn_layer0_ctrl: scoreboard bench for the layer-0 counter and sigmoid units
module tb_sigmoid_nn_layer0_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic ack = 1'b0;
  logic ack_mac;
  logic signed [7:0] z0 = '0;
  logic signed [7:0] z1 = '0;
  logic signed [7:0] a0, a1;
  int checks = 0;
  int failures = 0;
  int mcnt = 0;
  bit exp_q[$];
  int ea_q[$];

  sigmoid_nn_layer0_ctrl dut (
    .clk(clk), .rst(rst), .ack(ack), .ack_mac(ack_mac),
    .z0_value(z0), .z1_value(z1), .a0(a0), .a1(a1)
  );

  always #5 clk = ~clk;

  function automatic int sig_ref(input int z);
    real r;
    r = 16.0 / (1.0 + $exp(-$itor(z) / 16.0));
    return int'($floor(r + 0.5));
  endfunction

  task automatic drive(input bit v);
    ack = v;
    @(posedge clk);
    #1;
    if (rst && v && mcnt < 2) mcnt++;
    if (!rst) mcnt = 0;
    exp_q.push_back(mcnt == 2);
  endtask

  task automatic test_reset;
    bit e;
    rst = 1'b0;
    mcnt = 0;
    for (int i = 0; i < 2; i++) begin
      drive(1'b0);
      e = exp_q.pop_front();
      checks++;
      if (ack_mac !== e) begin failures++; $display("FAIL reset_hold cyc=%0d ack_mac=%b exp=%b", i, ack_mac, e); end
    end
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(1'b0);
      e = exp_q.pop_front();
      checks++;
      if (ack_mac !== e) begin failures++; $display("FAIL reset_idle cyc=%0d ack_mac=%b exp=%b", i, ack_mac, e); end
    end
  endtask

  task automatic test_separated;
    bit e;
    for (int i = 0; i < 28; i++) begin
      drive(i == 3 || i == 7);
      e = exp_q.pop_front();
      checks++;
      if (ack_mac !== e) begin failures++; $display("FAIL separated cyc=%0d ack_mac=%b exp=%b", i, ack_mac, e); end
    end
  endtask

  task automatic do_reset;
    #3 rst = 1'b0;
    mcnt = 0;
    #1 rst = 1'b1;
  endtask

  task automatic test_back_to_back;
    bit e;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      drive(i < 2 || (i >= 4 && i < 7));
      e = exp_q.pop_front();
      checks++;
      if (ack_mac !== e) begin failures++; $display("FAIL back_to_back cyc=%0d ack_mac=%b exp=%b", i, ack_mac, e); end
    end
  endtask

  task automatic test_async_reset;
    bit e;
    #3 rst = 1'b0;
    mcnt = 0;
    #1;
    checks++;
    if (ack_mac !== 1'b0) begin failures++; $display("FAIL async_clear_high ack_mac=%b exp=0", ack_mac); end
    rst = 1'b1;
    drive(1'b1);
    e = exp_q.pop_front();
    checks++;
    if (ack_mac !== e) begin failures++; $display("FAIL async_first_ack ack_mac=%b exp=%b", ack_mac, e); end
    ack = 1'b0;
    #3 rst = 1'b0;
    mcnt = 0;
    #1 rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(i < 2);
      e = exp_q.pop_front();
      checks++;
      if (ack_mac !== e) begin failures++; $display("FAIL async_recount cyc=%0d ack_mac=%b exp=%b", i, ack_mac, e); end
    end
    ack = 1'b0;
  endtask

  task automatic test_sigmoid_sweep;
    int e0, e1;
    for (int i = -128; i < 128; i++) begin
      z0 = 8'(i);
      z1 = 8'(-1 - i);
      ea_q.push_back(sig_ref(i));
      ea_q.push_back(sig_ref(-1 - i));
      #1;
      e0 = ea_q.pop_front();
      e1 = ea_q.pop_front();
      checks++;
      if (int'(a0) !== e0) begin failures++; $display("FAIL sweep_a0 z=%0d a0=%0d exp=%0d", i, a0, e0); end
      checks++;
      if (int'(a1) !== e1) begin failures++; $display("FAIL sweep_a1 z=%0d a1=%0d exp=%0d", -1 - i, a1, e1); end
    end
  endtask

  task automatic test_anchors;
    int zs[7] = '{-128, -32, -16, 0, 16, 32, 127};
    int as[7] = '{0, 2, 4, 8, 12, 14, 16};
    for (int i = 0; i < 7; i++) begin
      z0 = 8'(zs[i]);
      z1 = 8'(zs[i]);
      #1;
      checks++;
      if (int'(a0) !== as[i] || int'(a1) !== as[i]) begin
        failures++;
        $display("FAIL anchor z=%0d a0=%0d a1=%0d exp=%0d", zs[i], a0, a1, as[i]);
      end
    end
  endtask

  task automatic test_independence;
    z0 = 8'sd16;
    z1 = -8'sd16;
    #1;
    checks++;
    if (a0 !== 8'sd12 || a1 !== 8'sd4) begin failures++; $display("FAIL indep_pair a0=%0d a1=%0d exp=12/4", a0, a1); end
    z1 = 8'sd100;
    #1;
    checks++;
    if (a0 !== 8'sd12 || a1 !== 8'sd16) begin failures++; $display("FAIL indep_change a0=%0d a1=%0d exp=12/16", a0, a1); end
  endtask

  initial begin
    test_reset();
    test_separated();
    test_back_to_back();
    test_async_reset();
    test_sigmoid_sweep();
    test_anchors();
    test_independence();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
